oam_dma_ctrl: RTL
=================

Name: oam_dma_ctrl

Overview:
Sequences the $4014 OAM DMA transfer. It copies 256 bytes from CPU address space page {dma_page, 8'h00} into PPU OAM through repeated writes to PPU register 4 (OAMDATA). It drives the PPU's cs/rw/address/data register interface and the shared CPU memory read port, holding the 6502 stalled for the whole transfer. The block sits between the CPU bus decode and the PPU in the top level, and is muxed onto the PPU register port while busy.

Parameters:
XFER_LEN, 256, number of bytes transferred per DMA (power of two, at most 256).
OAMDATA_REG, 3'h4, PPU register index written for each byte.

Ports:
clk  input  1  system clock (PPU clock domain)
rst_n  input  1  asynchronous active-low reset
cpu_ce  input  1  one-clk pulse marking each CPU cycle boundary; all state advances only on cpu_ce
dma_start  input  1  one-clk pulse from the $4014 write decode
dma_page  input  8  source page, sampled with dma_start
mem_rdata  input  8  CPU memory read data, valid at cpu_ce ending a read cycle
mem_addr  output  16  CPU memory read address
mem_rd  output  1  memory read strobe
cpu_stall  output  1  1 = hold the 6502 (drives RDY low)
ppu_cs_n  output  1  PPU chip select, active low
ppu_rw  output  1  0 = write (matches the PPU's WRITE=1 inverted by top-level glue; block drives 1 for read/idle)
ppu_addr  output  3  PPU register select
ppu_wdata  output  8  byte written to OAMDATA
busy  output  1  transfer in progress
dma_done  output  1  one-clk pulse when the final byte is written

Behaviour:
- Reset values: state IDLE, mem_addr 0, mem_rd 0, cpu_stall 0, ppu_cs_n 1, ppu_rw 1, ppu_addr 0, ppu_wdata 0, busy 0, dma_done 0, byte index 0, parity 0.
- Parity flag toggles on every cpu_ce regardless of state. It tracks CPU get/put cycles.
- States: IDLE, HALT, ALIGN, READ, WRITE.
- IDLE: on dma_start, latch dma_page, clear the index, set busy and cpu_stall on the next clk, and go to HALT.
- HALT: one CPU cycle (dummy). At the ending cpu_ce, go to ALIGN if parity is 1, otherwise go to READ.
- ALIGN: one CPU cycle, then READ.
- READ: mem_addr = {page, index} and mem_rd = 1 for the whole CPU cycle. At the ending cpu_ce, capture mem_rdata into ppu_wdata and go to WRITE.
- WRITE: ppu_cs_n = 0, ppu_rw = 0, ppu_addr = OAMDATA_REG for exactly one CPU cycle, so the PPU sees one falling edge of cs per byte. At the ending cpu_ce, increment the index.
  - If the index was XFER_LEN-1: go to IDLE, pulse dma_done, and clear busy and cpu_stall in the same clk.
  - Otherwise go to READ.
- ppu_cs_n returns to 1 in every non-WRITE state. Back-to-back bytes therefore always separate cs falling edges by one high cycle.
- Transfer length is 1 + align + 2*XFER_LEN CPU cycles, i.e. 513 or 514 at the default.
- The index is 8 bits and wraps to 0 after 255. The page does not increment.
- dma_start while busy is ignored. The page is not re-latched.
- dma_start coincident with cpu_ce in IDLE: accepted. HALT begins at the following CPU cycle.
- cpu_ce held low: all state and outputs freeze.
- rst_n asserted mid-transfer: immediate return to reset values with no partial-write completion. OAM contents written so far remain as written.
- The top level muxes ppu_* over the CPU's own PPU register lines whenever busy = 1.

Optional Feature:
OAM_DMA_ODD_ALIGN_EN.
- Defined: the ALIGN state is used when the HALT cycle ends on odd parity, giving 513/514-cycle timing.
- Undefined: ALIGN is never entered, timing is a fixed 513 cycles, and the parity flag is removed.

Decomposition:
- Package oam_dma_pkg holds:
  - state enum (IDLE, HALT, ALIGN, READ, WRITE)
  - PPU_REG_OAMDATA = 3'h4
  - PPU_RW_READ = 1, PPU_RW_WRITE = 0
  - DMA_LEN_DEFAULT = 256
- No sub-module. The FSM, index counter and parity flag are one module.

Test Plan:
1. Page 8'h02 preloaded with bytes 0x00..0xFF, dma_start on even parity -> 256 OAMDATA writes with values 0x00..0xFF in order; cpu_stall high for exactly 513 cpu_ce; single dma_done pulse.
2. Same transfer started on odd parity with the macro defined -> 514 cycles and identical data. With the macro undefined -> 513 cycles.
3. Second dma_start pulsed at byte 100 with dma_page 8'h07 -> ignored; all 256 reads still hit 0x02xx; no extra writes.
4. rst_n pulsed low after byte 37 -> outputs return to reset values within the reset assertion; ppu_cs_n = 1; cpu_stall = 0; the next dma_start performs a full 256-byte transfer from index 0.
5. cpu_ce gated off for 20 clks mid-WRITE -> ppu_cs_n stays 0 and exactly one cs falling edge is produced for that byte.
6. dma_page 8'hFF -> mem_addr runs 0xFF00..0xFFFF with no carry into the page, and the transfer then returns to IDLE.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// Shared types and constants for the $4014 OAM DMA sequencer.
package oam_dma_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [2:0] PPU_REG_OAMDATA = 3'h4;
  localparam logic       PPU_RW_READ     = 1'b1;
  localparam logic       PPU_RW_WRITE    = 1'b0;
  localparam int         DMA_LEN_DEFAULT = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// OAM DMA: copies XFER_LEN bytes from page {dma_page,8'h00} to PPU OAMDATA in 1+align+2*XFER_LEN CPU cycles.
// No backpressure beyond cpu_ce gating; define OAM_DMA_ODD_ALIGN_EN to insert the odd-parity ALIGN cycle.
module oam_dma_ctrl
  import oam_dma_pkg::*;
#(
  parameter int         XFER_LEN    = DMA_LEN_DEFAULT,
  parameter logic [2:0] OAMDATA_REG = PPU_REG_OAMDATA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_ce,
  input  logic        dma_start,
  input  logic [7:0]  dma_page,
  input  logic [7:0]  mem_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        cpu_stall,
  output logic        ppu_cs_n,
  output logic        ppu_rw,
  output logic [2:0]  ppu_addr,
  output logic [7:0]  ppu_wdata,
  output logic        busy,
  output logic        dma_done
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_t state, state_nxt;
  logic [7:0] page, page_nxt;
  logic [7:0] idx, idx_nxt;
  logic [7:0] wdata_q, wdata_nxt;
  logic       done_q, done_nxt;

`ifdef OAM_DMA_ODD_ALIGN_EN
  logic parity;

  // Tracks CPU get/put cycles independently of the transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      parity <= 1'b0;
    else if (cpu_ce) parity <= ~parity;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      page    <= 8'h00;
      idx     <= 8'h00;
      wdata_q <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      page    <= page_nxt;
      idx     <= idx_nxt;
      wdata_q <= wdata_nxt;
      done_q  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    page_nxt  = page;
    idx_nxt   = idx;
    wdata_nxt = wdata_q;
    done_nxt  = 1'b0;

    // dma_start is accepted on any clk in IDLE; every later step waits for cpu_ce.
    case (state)
      IDLE: begin
        if (dma_start) begin
          state_nxt = HALT;
          page_nxt  = dma_page;
          idx_nxt   = 8'h00;
        end
      end
      HALT: begin
        if (cpu_ce) begin
`ifdef OAM_DMA_ODD_ALIGN_EN
          state_nxt = parity ? ALIGN : READ;
`else
          state_nxt = READ;
`endif
        end
      end
      ALIGN: begin
        if (cpu_ce) state_nxt = READ;
      end
      READ: begin
        if (cpu_ce) begin
          wdata_nxt = mem_rdata;
          state_nxt = WRITE;
        end
      end
      WRITE: begin
        if (cpu_ce) begin
          idx_nxt = idx + 8'd1;
          if (idx == LAST_IDX) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = READ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_addr  = 16'h0000;
    mem_rd    = 1'b0;
    ppu_cs_n  = 1'b1;
    ppu_rw    = PPU_RW_READ;
    ppu_addr  = 3'h0;
    busy      = (state != IDLE);
    cpu_stall = (state != IDLE);
    ppu_wdata = wdata_q;
    dma_done  = done_q;

    if (state == READ) begin
      mem_addr = {page, idx};
      mem_rd   = 1'b1;
    end
    if (state == WRITE) begin
      ppu_cs_n = 1'b0;
      ppu_rw   = PPU_RW_WRITE;
      ppu_addr = OAMDATA_REG;
    end
  end

endmodule
